// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if
//   Groups the signals around the ID->EX operand stage: the decode slot
//   fields, the register-file read data, the WB bypass inputs, the flush
//   input, the stall output and the registered EX-slot outputs.
//   Parameters:
//     N      datapath width
//     CNT_W  width of the stall_count performance counter
//   Modports:
//     master  the surrounding pipeline; drives id_*, rf_*, wb_* and flush,
//             and observes stall, ex_* and stall_count
//     slave   the operand stage itself
interface id_ex_operand_stage_if #(
    parameter int N     = 32,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_is_load;
    logic             id_reg_write;
    logic [N-1:0]     rf_rdata1;
    logic [N-1:0]     rf_rdata2;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;
    logic [N-1:0]     wb_data;
    logic             flush;
    logic             stall;
    logic             ex_valid;
    logic [N-1:0]     ex_rs1_val;
    logic [N-1:0]     ex_rs2_val;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_is_load;
    logic             ex_reg_write;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_is_load, id_reg_write, rf_rdata1, rf_rdata2,
               wb_reg_write, wb_rd, wb_data, flush,
        input  stall, ex_valid, ex_rs1_val, ex_rs2_val, ex_rs1, ex_rs2,
               ex_rd, ex_is_load, ex_reg_write, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_is_load, id_reg_write, rf_rdata1, rf_rdata2,
               wb_reg_write, wb_rd, wb_data, flush,
        output stall, ex_valid, ex_rs1_val, ex_rs2_val, ex_rs1, ex_rs2,
               ex_rd, ex_is_load, ex_reg_write, stall_count
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID->EX pipeline register of the RV32 core. Selects operands from the
//   register file with a WB->ID bypass (the regfile writes at the edge, so a
//   same-cycle WB write is not yet visible on its read ports), detects
//   load-use hazards, and registers operands plus control into the EX slot.
//   Keeps a saturating count of load-use stall cycles.
//   Ports:
//     clk    clock, all state updates on posedge
//     reset  synchronous, active-high; clears the EX slot and the counter
//     bus    id_ex_operand_stage_if.slave (see the interface for fields)
//
//   Valid semantics: there is no ready on this stage. id_valid marks a real
//   instruction in decode; when stall=1 the upstream stages hold PC and IF/ID
//   so the same instruction is re-presented next cycle while a bubble
//   (ex_valid=0) enters EX. ex_valid marks a real instruction in EX, and
//   ex_reg_write/ex_is_load are only ever 1 while ex_valid=1.
module id_ex_operand_stage #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input logic                  clk,
    input logic                  reset,
    id_ex_operand_stage_if.slave bus
);
    logic [N-1:0]     op1;
    logic [N-1:0]     op2;
    logic             stall_int;
    logic             hit_rs1;
    logic             hit_rs2;

    logic             ex_valid_q;
    logic [N-1:0]     ex_rs1_val_q;
    logic [N-1:0]     ex_rs2_val_q;
    logic [4:0]       ex_rs1_q;
    logic [4:0]       ex_rs2_q;
    logic [4:0]       ex_rd_q;
    logic             ex_is_load_q;
    logic             ex_reg_write_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Operand select: x0 is hard-wired to zero even if WB targets it.
    always_comb begin
        op1 = bus.rf_rdata1;
        if (bus.id_rs1 == 5'd0) begin
            op1 = '0;
        end else if (bus.wb_reg_write && (bus.wb_rd == bus.id_rs1)) begin
            op1 = bus.wb_data;
        end
    end

    always_comb begin
        op2 = bus.rf_rdata2;
        if (bus.id_rs2 == 5'd0) begin
            op2 = '0;
        end else if (bus.wb_reg_write && (bus.wb_rd == bus.id_rs2)) begin
            op2 = bus.wb_data;
        end
    end

    // Load-use hazard: the load's data is only available after MEM, so a
    // consumer directly behind it must wait one cycle. A flush kills the
    // consumer anyway, so it never stalls.
    assign hit_rs1   = bus.id_uses_rs1 && (bus.id_rs1 == ex_rd_q);
    assign hit_rs2   = bus.id_uses_rs2 && (bus.id_rs2 == ex_rd_q);
    assign stall_int = bus.id_valid && !bus.flush && ex_valid_q && ex_is_load_q &&
                       (ex_rd_q != 5'd0) && (hit_rs1 || hit_rs2);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_rs1_val_q   <= '0;
            ex_rs2_val_q   <= '0;
            ex_rs1_q       <= 5'd0;
            ex_rs2_q       <= 5'd0;
            ex_rd_q        <= 5'd0;
            ex_is_load_q   <= 1'b0;
            ex_reg_write_q <= 1'b0;
        end else if (bus.flush || stall_int) begin
            // Bubble: kill control only, data/index fields keep their value.
            ex_valid_q     <= 1'b0;
            ex_is_load_q   <= 1'b0;
            ex_reg_write_q <= 1'b0;
        end else begin
            ex_valid_q     <= bus.id_valid;
            ex_rs1_val_q   <= op1;
            ex_rs2_val_q   <= op2;
            ex_rs1_q       <= bus.id_rs1;
            ex_rs2_q       <= bus.id_rs2;
            ex_rd_q        <= bus.id_rd;
            ex_is_load_q   <= bus.id_valid && bus.id_is_load;
            ex_reg_write_q <= bus.id_valid && bus.id_reg_write;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_int && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall        = stall_int;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_rs1_val   = ex_rs1_val_q;
    assign bus.ex_rs2_val   = ex_rs2_val_q;
    assign bus.ex_rs1       = ex_rs1_q;
    assign bus.ex_rs2       = ex_rs2_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_is_load   = ex_is_load_q;
    assign bus.ex_reg_write = ex_reg_write_q;
    assign bus.stall_count  = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: a default instance (CNT_W=16) and a
// CNT_W=2 instance share the same stimulus. A per-cycle reference model
// predicts the EX slot and stall count; directed steps add literal checks.
module tb_id_ex_operand_stage;
    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stimulus signals ----------------
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_is_load, id_reg_write;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [31:0] rf_rdata1, rf_rdata2, wb_data;
    logic        wb_reg_write, flush;

    id_ex_operand_stage_if #(.N(32), .CNT_W(16)) bus_a ();
    id_ex_operand_stage_if #(.N(32), .CNT_W(2))  bus_b ();

    assign bus_a.id_valid     = id_valid;
    assign bus_a.id_rs1       = id_rs1;
    assign bus_a.id_rs2       = id_rs2;
    assign bus_a.id_rd        = id_rd;
    assign bus_a.id_uses_rs1  = id_uses_rs1;
    assign bus_a.id_uses_rs2  = id_uses_rs2;
    assign bus_a.id_is_load   = id_is_load;
    assign bus_a.id_reg_write = id_reg_write;
    assign bus_a.rf_rdata1    = rf_rdata1;
    assign bus_a.rf_rdata2    = rf_rdata2;
    assign bus_a.wb_reg_write = wb_reg_write;
    assign bus_a.wb_rd        = wb_rd;
    assign bus_a.wb_data      = wb_data;
    assign bus_a.flush        = flush;

    assign bus_b.id_valid     = id_valid;
    assign bus_b.id_rs1       = id_rs1;
    assign bus_b.id_rs2       = id_rs2;
    assign bus_b.id_rd        = id_rd;
    assign bus_b.id_uses_rs1  = id_uses_rs1;
    assign bus_b.id_uses_rs2  = id_uses_rs2;
    assign bus_b.id_is_load   = id_is_load;
    assign bus_b.id_reg_write = id_reg_write;
    assign bus_b.rf_rdata1    = rf_rdata1;
    assign bus_b.rf_rdata2    = rf_rdata2;
    assign bus_b.wb_reg_write = wb_reg_write;
    assign bus_b.wb_rd        = wb_rd;
    assign bus_b.wb_data      = wb_data;
    assign bus_b.flush        = flush;

    id_ex_operand_stage #(.N(32), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    id_ex_operand_stage #(.N(32), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    // The EX slot is modelled as the instruction that was accepted last;
    // a bubble keeps the old fields but is not an instruction.
    typedef struct {
        logic        valid;
        logic [31:0] v1, v2;
        logic [4:0]  rs1, rs2, rd;
        logic        ld, rw;
    } ex_slot_t;

    ex_slot_t m;
    int       m_stalls;
    bit       m_known = 0;

    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
        if (wb_reg_write && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    function automatic logic model_stall();
        logic dep;
        dep = (id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
        return id_valid && !flush && m.valid && m.ld && m.rd != 5'd0 && dep;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Compare on the falling edge, then advance the model with the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin
        logic st;
        if (m_known) begin
            st = model_stall();
            chk("stall",         {31'd0, bus_a.stall},        {31'd0, st});
            chk("ex_valid",      {31'd0, bus_a.ex_valid},     {31'd0, m.valid});
            chk("ex_rs1_val",    bus_a.ex_rs1_val,            m.v1);
            chk("ex_rs2_val",    bus_a.ex_rs2_val,            m.v2);
            chk("ex_rs1",        {27'd0, bus_a.ex_rs1},       {27'd0, m.rs1});
            chk("ex_rs2",        {27'd0, bus_a.ex_rs2},       {27'd0, m.rs2});
            chk("ex_rd",         {27'd0, bus_a.ex_rd},        {27'd0, m.rd});
            chk("ex_is_load",    {31'd0, bus_a.ex_is_load},   {31'd0, m.ld});
            chk("ex_reg_write",  {31'd0, bus_a.ex_reg_write}, {31'd0, m.rw});
            chk("stall_count16", {16'd0, bus_a.stall_count},  32'(sat(m_stalls, 65535)));
            chk("stall_count2",  {30'd0, bus_b.stall_count},  32'(sat(m_stalls, 3)));
            chk("b_ex_valid",    {31'd0, bus_b.ex_valid},     {31'd0, m.valid});
        end
        if (reset) begin
            m = '{valid: 1'b0, v1: 32'd0, v2: 32'd0, rs1: 5'd0, rs2: 5'd0,
                  rd: 5'd0, ld: 1'b0, rw: 1'b0};
            m_stalls = 0;
            m_known  = 1;
        end else if (m_known) begin
            if (model_stall()) m_stalls++;
            if (flush || model_stall()) begin
                m.valid = 1'b0;
                m.ld    = 1'b0;
                m.rw    = 1'b0;
            end else begin
                m.valid = id_valid;
                m.v1    = operand(id_rs1, rf_rdata1);
                m.v2    = operand(id_rs2, rf_rdata2);
                m.rs1   = id_rs1;
                m.rs2   = id_rs2;
                m.rd    = id_rd;
                m.ld    = id_valid && id_is_load;
                m.rw    = id_valid && id_reg_write;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input logic ld, input logic rw);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_is_load = ld; id_reg_write = rw;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        wb_reg_write = we; wb_rd = rd; wb_data = d;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
        rf_rdata1 = 32'd0;
        rf_rdata2 = 32'd0;
        repeat (2) tick();
        chk("rst_ex_valid",    {31'd0, bus_a.ex_valid}, 32'd0);
        chk("rst_ex_rs1_val",  bus_a.ex_rs1_val,        32'd0);
        chk("rst_stall_count", {16'd0, bus_a.stall_count}, 32'd0);
        reset = 1'b0;

        // WB->ID bypass: x5 holds 7 in the regfile, WB writes 9 this cycle
        set_id(1, 5, 3, 7, 1, 1, 0, 1);
        rf_rdata1 = 32'd7;
        rf_rdata2 = 32'h33;
        set_wb(1, 5, 32'd9);
        tick();
        chk("byp_rs1_val", bus_a.ex_rs1_val, 32'd9);
        chk("byp_rs2_val", bus_a.ex_rs2_val, 32'h33);
        chk("byp_valid",   {31'd0, bus_a.ex_valid}, 32'd1);
        chk("byp_rd",      {27'd0, bus_a.ex_rd},    32'd7);

        // same index but WB not writing -> regfile value
        set_wb(0, 5, 32'd9);
        tick();
        chk("nobyp_rs1_val", bus_a.ex_rs1_val, 32'd7);

        // bypass on source 2 only
        set_wb(1, 3, 32'h55);
        tick();
        chk("byp2_rs2_val", bus_a.ex_rs2_val, 32'h55);
        chk("byp2_rs1_val", bus_a.ex_rs1_val, 32'd7);

        // x0 stays zero even when WB targets it
        set_id(1, 0, 0, 4, 1, 1, 0, 1);
        rf_rdata1 = 32'h1234;
        set_wb(1, 0, 32'hDEAD);
        tick();
        chk("x0_rs1_val", bus_a.ex_rs1_val, 32'd0);

        // invalid decode slot: control forced off, indices still captured
        set_wb(0, 0, 0);
        set_id(0, 1, 2, 9, 1, 1, 1, 1);
        tick();
        chk("inv_valid", {31'd0, bus_a.ex_valid},     32'd0);
        chk("inv_rw",    {31'd0, bus_a.ex_reg_write}, 32'd0);
        chk("inv_ld",    {31'd0, bus_a.ex_is_load},   32'd0);
        chk("inv_rd",    {27'd0, bus_a.ex_rd},        32'd9);

        // load-use: lw x6 then add using x6 as rs2
        set_id(1, 2, 0, 6, 1, 0, 1, 1);
        tick();
        set_id(1, 1, 6, 8, 1, 1, 0, 1);
        #1;
        chk("lu_stall", {31'd0, bus_a.stall}, 32'd1);
        tick();
        chk("lu_bubble",      {31'd0, bus_a.ex_valid},    32'd0);
        chk("lu_stall_count", {16'd0, bus_a.stall_count}, 32'd1);
        chk("lu_stall_gone",  {31'd0, bus_a.stall},       32'd0);
        tick();
        chk("lu_resume_valid", {31'd0, bus_a.ex_valid}, 32'd1);
        chk("lu_resume_rd",    {27'd0, bus_a.ex_rd},    32'd8);

        // matching index but source not used -> no stall
        set_id(1, 2, 0, 6, 1, 0, 1, 1);
        tick();
        set_id(1, 6, 0, 8, 0, 0, 0, 1);
        #1;
        chk("unused_no_stall", {31'd0, bus_a.stall}, 32'd0);
        tick();

        // stall condition together with flush -> flush wins, no count
        set_id(1, 2, 0, 6, 1, 0, 1, 1);
        tick();
        set_id(1, 6, 0, 8, 1, 0, 0, 1);
        flush = 1'b1;
        #1;
        chk("fl_no_stall", {31'd0, bus_a.stall}, 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid",       {31'd0, bus_a.ex_valid},    32'd0);
        chk("fl_rd_held",     {27'd0, bus_a.ex_rd},       32'd6);
        chk("fl_stall_count", {16'd0, bus_a.stall_count}, 32'd1);

        // load into x0 never causes a stall
        set_id(1, 2, 0, 0, 1, 0, 1, 1);
        tick();
        set_id(1, 0, 0, 4, 1, 0, 0, 1);
        #1;
        chk("ld_x0_no_stall", {31'd0, bus_a.stall}, 32'd0);
        tick();

        // four more load-use stalls: 5 total, CNT_W=2 copy saturates at 3
        for (int i = 0; i < 4; i++) begin
            set_id(1, 2, 0, 6, 1, 0, 1, 1);
            tick();
            set_id(1, 6, 1, 8, 1, 0, 0, 1);
            tick();
        end
        chk("sat_count16", {16'd0, bus_a.stall_count}, 32'd5);
        chk("sat_count2",  {30'd0, bus_b.stall_count}, 32'd3);
        set_id(1, 2, 0, 6, 1, 0, 1, 1);
        tick();
        set_id(1, 6, 1, 8, 1, 0, 0, 1);
        tick();
        chk("sat_hold2",   {30'd0, bus_b.stall_count}, 32'd3);
        chk("sat_count16b", {16'd0, bus_a.stall_count}, 32'd6);

        // reset mid-operation drops the in-flight instruction
        set_id(1, 1, 2, 3, 1, 1, 0, 1);
        rf_rdata1 = 32'hAAAA;
        tick();
        chk("pre_rst_valid", {31'd0, bus_a.ex_valid},     32'd1);
        chk("pre_rst_rw",    {31'd0, bus_a.ex_reg_write}, 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid",   {31'd0, bus_a.ex_valid},     32'd0);
        chk("mid_rst_rw",      {31'd0, bus_a.ex_reg_write}, 32'd0);
        chk("mid_rst_rd",      {27'd0, bus_a.ex_rd},        32'd0);
        chk("mid_rst_rs1_val", bus_a.ex_rs1_val,            32'd0);
        chk("mid_rst_count16", {16'd0, bus_a.stall_count},  32'd0);
        chk("mid_rst_count2",  {30'd0, bus_b.stall_count},  32'd0);
        reset = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
